writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
Final pipeline stage and write side of the register-file/scoreboard interface that the decode stage reads. Accepts retired results from the MEM stage over a valid/ready handshake and buffers them in a 2-entry FIFO. Selects ALU versus load data and performs load-width extension. Drives the register-file write port (reg_write, reg_wr_addr_wb, reg_wr_data); reg_write also clears the decode-stage busy flag for reg_wr_addr_wb.

Parameters:
DATA_W, 32, register/data width
ADDR_W, 5, register address width
DEPTH, 2, buffer entries (power of 2, >=2)

Ports:
clk  in  1  pipeline clock
reset  in  1  synchronous, active-high reset
mem_valid  in  1  MEM stage presents a result
mem_ready  out  1  buffer can accept
mem_reg_write  in  1  instruction writes a register
mem_to_reg  in  1  1 = load data, 0 = ALU data
mem_rd  in  ADDR_W  destination register
alu_data_out  in  DATA_W  ALU result
mem_data_out  in  DATA_W  raw load data
load_size  in  2  00 word, 01 half, 10 byte, 11 word
load_unsigned  in  1  zero-extend, else sign-extend
stall_flag  in  1  global stall: hold the drain
reg_write  out  1  register-file write enable / scoreboard clear
reg_wr_addr_wb  out  ADDR_W  write address
reg_wr_data  out  DATA_W  write data
wb_busy  out  1  buffer non-empty or write pending
retired_count  out  32  retired-instruction counter

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: flushes the FIFO (count = 0, pointers = 0) and clears all outputs (reg_write, reg_wr_addr_wb, reg_wr_data, retired_count and wb_busy are 0). mem_ready is 1 in the first cycle after reset. Reset mid-operation discards buffered entries; no write is issued for them.
- mem_ready = (count != DEPTH). It is registered-state only; there is no combinational path from the pop to mem_ready.
- Push on a clk edge when mem_valid && mem_ready. The stored entry is {we = mem_reg_write, rd = mem_rd, data = selected value}.
- Data select at capture:
  - mem_to_reg = 0: alu_data_out.
  - mem_to_reg = 1, word: mem_data_out.
  - mem_to_reg = 1, half: mem_data_out[15:0], extended to DATA_W.
  - mem_to_reg = 1, byte: mem_data_out[7:0], extended to DATA_W.
  - Extension is sign or zero per load_unsigned.
- Pop on a clk edge when count != 0 && !stall_flag. The outputs register the head:
  - reg_write <= head.we && (head.rd != 0)
  - reg_wr_addr_wb <= head.rd
  - reg_wr_data <= head.data
- If there is no pop, reg_write <= 0; reg_wr_addr_wb and reg_wr_data hold their values.
- Latency: an entry pushed at edge N is popped at edge N+1 at the earliest. reg_write is high for exactly one cycle after that edge, so writes are single-cycle pulses.
- Register 0: the write is suppressed (reg_write = 0) but the entry still retires and counts.
- Simultaneous push and pop: allowed when 0 < count < DEPTH; count is unchanged. When full, there is no push even if a pop occurs in the same cycle.
- Pointers wrap modulo DEPTH.
- stall_flag high: no pop, and reg_write = 0 next cycle. Pushes continue while mem_ready is high.
- retired_count increments by 1 on every pop and wraps at 2^32-1 -> 0.
- wb_busy = (count != 0) || reg_write.

Optional Feature:
WB_FWD_EN
- Defined: adds outputs fwd_valid (1), fwd_addr (ADDR_W) and fwd_data (DATA_W). They are combinational from the youngest buffered entry whose we = 1 and rd != 0, otherwise from the registered write port while reg_write = 1. fwd_valid is 0 when neither exists. This lets decode bypass the register file and clear stalls one cycle earlier.
- Undefined: the ports are absent and there is no extra logic.

Test Plan:
- Reset, then push {we=1, rd=5, ALU=0x1234_5678} -> one edge later reg_write=1, addr=5, data=0x12345678 for one cycle; retired_count=1.
- Loads with mem_data_out=0x0000_80F0 -> half signed gives 0xFFFF80F0; half unsigned gives 0x000080F0; byte signed gives 0xFFFFFFF0; word gives 0x000080F0.
- Push rd=0, we=1 -> reg_write stays 0; retired_count increments.
- Hold stall_flag=1, push 3 results back-to-back -> mem_ready drops after 2 accepted. Release stall -> the third is accepted, and writes occur in order on consecutive cycles.
- Push we=0 rd=7 -> no write; the entry retires.
- Assert reset with 2 entries buffered -> no writes afterward; mem_ready=1 and retired_count=0 the next cycle.

Source files
------------

// File: rtl/writeback_unit.sv
// writeback_unit: final pipeline stage. Buffers retired MEM-stage results in a
// small FIFO, performs load data selection / width extension at capture, and
// drains one entry per cycle into the registered register-file write port.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   mem_valid/ready   MEM-stage result handshake (ready = buffer not full)
//   mem_reg_write     instruction writes a register
//   mem_to_reg        1 = load data, 0 = ALU data
//   mem_rd            destination register
//   alu_data_out      ALU result
//   mem_data_out      raw load data
//   load_size         00 word, 01 half, 10 byte, 11 word
//   load_unsigned     zero-extend loads, else sign-extend
//   stall_flag        hold the drain
//   reg_write         one-cycle write enable / scoreboard clear
//   reg_wr_addr_wb    write address
//   reg_wr_data       write data
//   wb_busy           buffer non-empty or write pending
//   retired_count     retired-instruction counter (wraps)
//
// Optional feature (macro WB_FWD_EN): adds fwd_valid/fwd_addr/fwd_data, a
// combinational bypass of the youngest pending register write.
module writeback_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic              mem_reg_write,
  input  logic              mem_to_reg,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] alu_data_out,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic [1:0]        load_size,
  input  logic              load_unsigned,
  input  logic              stall_flag,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_wr_addr_wb,
  output logic [DATA_W-1:0] reg_wr_data,
  output logic              wb_busy,
  output logic [31:0]       retired_count
`ifdef WB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic              we_q   [DEPTH];
  logic [ADDR_W-1:0] rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;
  logic [DATA_W-1:0] sel_data;

  assign mem_ready = (count_q != CNT_W'(DEPTH));
  assign push      = mem_valid && mem_ready;
  assign pop       = (count_q != '0) && !stall_flag;
  assign wb_busy   = (count_q != '0) || reg_write;

  // Load data select and width extension happen at capture so the drain
  // path is a plain register copy.
  always_comb begin
    logic ext;
    sel_data = alu_data_out;
    ext      = 1'b0;
    if (mem_to_reg) begin
      unique case (load_size)
        2'b01: begin
          ext      = !load_unsigned && mem_data_out[15];
          sel_data = {{(DATA_W-16){ext}}, mem_data_out[15:0]};
        end
        2'b10: begin
          ext      = !load_unsigned && mem_data_out[7];
          sel_data = {{(DATA_W-8){ext}}, mem_data_out[7:0]};
        end
        default: sel_data = mem_data_out;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Entry storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      we_q[wr_ptr_q]   <= mem_reg_write;
      rd_q[wr_ptr_q]   <= mem_rd;
      data_q[wr_ptr_q] <= sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      reg_write      <= 1'b0;
      reg_wr_addr_wb <= '0;
      reg_wr_data    <= '0;
      retired_count  <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q       <= rd_ptr_q + PTR_W'(1);
        // Writes to x0 retire and count but never reach the register file.
        reg_write      <= we_q[rd_ptr_q] && (rd_q[rd_ptr_q] != '0);
        reg_wr_addr_wb <= rd_q[rd_ptr_q];
        reg_wr_data    <= data_q[rd_ptr_q];
        retired_count  <= retired_count + 32'd1;
      end else begin
        reg_write <= 1'b0;
      end
    end
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the youngest qualifying entry wins; fall back
  // to the write port only when nothing buffered qualifies.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_valid = reg_write;
    fwd_addr  = reg_wr_addr_wb;
    fwd_data  = reg_wr_data;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((i < int'(count_q)) && we_q[idx] && (rd_q[idx] != '0)) begin
        fwd_valid = 1'b1;
        fwd_addr  = rd_q[idx];
        fwd_data  = data_q[idx];
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_reg_write;
  logic        mem_to_reg;
  logic [4:0]  mem_rd;
  logic [31:0] alu_data_out;
  logic [31:0] mem_data_out;
  logic [1:0]  load_size;
  logic        load_unsigned;
  logic        stall_flag;
  logic        reg_write;
  logic [4:0]  reg_wr_addr_wb;
  logic [31:0] reg_wr_data;
  logic        wb_busy;
  logic [31:0] retired_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_retired = 32'd0;

  always #5 clk = ~clk;

  writeback_unit #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_reg_write  (mem_reg_write),
    .mem_to_reg     (mem_to_reg),
    .mem_rd         (mem_rd),
    .alu_data_out   (alu_data_out),
    .mem_data_out   (mem_data_out),
    .load_size      (load_size),
    .load_unsigned  (load_unsigned),
    .stall_flag     (stall_flag),
    .reg_write      (reg_write),
    .reg_wr_addr_wb (reg_wr_addr_wb),
    .reg_wr_data    (reg_wr_data),
    .wb_busy        (wb_busy),
    .retired_count  (retired_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present one entry at the current falling edge; return one falling edge
  // after the accepting rising edge with mem_valid dropped.
  task automatic push_one(input logic we, input logic [4:0] rd, input logic m2r,
                          input logic [31:0] alu, input logic [31:0] mem,
                          input logic [1:0] size, input logic uns);
    mem_valid     = 1'b1;
    mem_reg_write = we;
    mem_rd        = rd;
    mem_to_reg    = m2r;
    alu_data_out  = alu;
    mem_data_out  = mem;
    load_size     = size;
    load_unsigned = uns;
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  task automatic set_entry(input logic [4:0] rd, input logic [31:0] alu);
    mem_valid     = 1'b1;
    mem_reg_write = 1'b1;
    mem_rd        = rd;
    mem_to_reg    = 1'b0;
    alu_data_out  = alu;
  endtask

  // Advance past the pop edge and check the write port.
  task automatic expect_write(input string tag, input logic we, input logic [4:0] rd,
                              input logic [31:0] data);
    @(negedge clk);
    exp_retired = exp_retired + 32'd1;
    check_eq({tag, "_we"}, {31'd0, reg_write}, {31'd0, we});
    check_eq({tag, "_addr"}, {27'd0, reg_wr_addr_wb}, {27'd0, rd});
    if (we) check_eq({tag, "_data"}, reg_wr_data, data);
    check_eq({tag, "_retired"}, retired_count, exp_retired);
  endtask

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_reg_write = 1'b0; mem_to_reg = 1'b0;
    mem_rd = '0; alu_data_out = '0; mem_data_out = '0; load_size = 2'b00;
    load_unsigned = 1'b0; stall_flag = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'd0, mem_ready}, 32'd1);
    check_eq("rst_we", {31'd0, reg_write}, 32'd0);
    check_eq("rst_busy", {31'd0, wb_busy}, 32'd0);
    check_eq("rst_retired", retired_count, 32'd0);
    check_eq("rst_data", reg_wr_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic ALU write: pulse lasts exactly one cycle.
    push_one(1'b1, 5'd5, 1'b0, 32'h1234_5678, 32'h0, 2'b00, 1'b0);
    check_eq("alu_busy", {31'd0, wb_busy}, 32'd1);
    check_eq("alu_nowe_yet", {31'd0, reg_write}, 32'd0);
    expect_write("alu", 1'b1, 5'd5, 32'h1234_5678);
    @(negedge clk);
    check_eq("alu_pulse_end", {31'd0, reg_write}, 32'd0);
    check_eq("alu_idle", {31'd0, wb_busy}, 32'd0);

    // Load extension.
    push_one(1'b1, 5'd1, 1'b1, 32'hDEAD_BEEF, 32'h0000_80F0, 2'b01, 1'b0);
    expect_write("half_s", 1'b1, 5'd1, 32'hFFFF_80F0);
    push_one(1'b1, 5'd2, 1'b1, 32'hDEAD_BEEF, 32'h0000_80F0, 2'b01, 1'b1);
    expect_write("half_u", 1'b1, 5'd2, 32'h0000_80F0);
    push_one(1'b1, 5'd3, 1'b1, 32'hDEAD_BEEF, 32'h0000_80F0, 2'b10, 1'b0);
    expect_write("byte_s", 1'b1, 5'd3, 32'hFFFF_FFF0);
    push_one(1'b1, 5'd4, 1'b1, 32'hDEAD_BEEF, 32'h0000_80F0, 2'b10, 1'b1);
    expect_write("byte_u", 1'b1, 5'd4, 32'h0000_00F0);
    push_one(1'b1, 5'd6, 1'b1, 32'hDEAD_BEEF, 32'h0000_80F0, 2'b00, 1'b0);
    expect_write("word", 1'b1, 5'd6, 32'h0000_80F0);
    push_one(1'b1, 5'd8, 1'b1, 32'hDEAD_BEEF, 32'h8765_4321, 2'b11, 1'b0);
    expect_write("word11", 1'b1, 5'd8, 32'h8765_4321);

    // x0 suppressed but retired.
    push_one(1'b1, 5'd0, 1'b0, 32'hAAAA_5555, 32'h0, 2'b00, 1'b0);
    expect_write("rd0", 1'b0, 5'd0, 32'h0);

    // Stall fills the buffer; drain writes in order on consecutive cycles.
    stall_flag = 1'b1;
    set_entry(5'd10, 32'h0000_000A);
    @(negedge clk);
    set_entry(5'd11, 32'h0000_000B);
    @(negedge clk);
    check_eq("full_ready", {31'd0, mem_ready}, 32'd0);
    set_entry(5'd12, 32'h0000_000C);
    @(negedge clk);
    check_eq("stall_ready", {31'd0, mem_ready}, 32'd0);
    check_eq("stall_we", {31'd0, reg_write}, 32'd0);
    check_eq("stall_retired", retired_count, exp_retired);
    stall_flag = 1'b0;
    expect_write("drain0", 1'b1, 5'd10, 32'h0000_000A);
    check_eq("drain0_ready", {31'd0, mem_ready}, 32'd1);
    expect_write("drain1", 1'b1, 5'd11, 32'h0000_000B);
    mem_valid = 1'b0;
    expect_write("drain2", 1'b1, 5'd12, 32'h0000_000C);
    @(negedge clk);
    check_eq("drain_idle", {31'd0, wb_busy}, 32'd0);

    // we=0 retires with no write.
    push_one(1'b0, 5'd7, 1'b0, 32'h1111_1111, 32'h0, 2'b00, 1'b0);
    expect_write("we0", 1'b0, 5'd7, 32'h0);

    // Reset with two entries buffered discards them.
    stall_flag = 1'b1;
    set_entry(5'd20, 32'h0000_0014);
    @(negedge clk);
    set_entry(5'd21, 32'h0000_0015);
    @(negedge clk);
    mem_valid  = 1'b0;
    stall_flag = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("mid_rst_ready", {31'd0, mem_ready}, 32'd1);
    check_eq("mid_rst_retired", retired_count, 32'd0);
    check_eq("mid_rst_busy", {31'd0, wb_busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("post_rst_we", {31'd0, reg_write}, 32'd0);
    end
    check_eq("post_rst_retired", retired_count, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
